// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: decode-side control (stall/flush/branch redirect),
// the instruction SRAM port, and the IF/ID register outputs to decode.
//   master : the fetch stage (drives SRAM request and decode outputs)
//   slave  : the surrounding core / SRAM / decode side
interface fetch_stage_if;
   logic        stall;
   logic        flush;
   logic [31:0] newpc;
   logic        branch_d;
   logic        branch_taken;
   logic [31:0] branch_target;

   logic        inst_sram_en;
   logic [3:0]  inst_sram_wen;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic [31:0] inst_sram_rdata;

   logic [31:0] pc_d;
   logic [31:0] instr_d;
   logic        valid_d;
   logic        adel_d;
   logic        in_delayslot_d;

   modport master (
      input  stall, flush, newpc, branch_d, branch_taken, branch_target,
      input  inst_sram_rdata,
      output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
      output pc_d, instr_d, valid_d, adel_d, in_delayslot_d
   );

   modport slave (
      output stall, flush, newpc, branch_d, branch_taken, branch_target,
      output inst_sram_rdata,
      input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
      input  pc_d, instr_d, valid_d, adel_d, in_delayslot_d
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register.
// Drives pc_f onto a 1-cycle-latency instruction SRAM and presents
// {pc_d, instr_d, valid_d, adel_d, in_delayslot_d} to decode.
// Ports:
//   clk     : clock, all state on rising edge
//   resetn  : synchronous reset, active-low
//   bus     : fetch_stage_if.master (control in, SRAM port, decode outputs)
// Edge priority: reset > flush > stall > branch_taken > sequential pc_f+4.
// A one-entry skid buffer holds the decode instruction during a stall,
// because the SRAM keeps reading pc_f and its output moves on to the next word.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
   input  logic         clk,
   input  logic         resetn,
   fetch_stage_if.master bus
);

   logic [31:0] pc_f_q,      pc_f_d;
   logic [31:0] dec_pc_q,    dec_pc_d;
   logic        dec_valid_q, dec_valid_d;
   logic        dec_adel_q,  dec_adel_d;
   logic        dec_ds_q,    dec_ds_d;
   logic        buf_valid_q, buf_valid_d;
   logic [31:0] buf_instr_q, buf_instr_d;

   logic        pc_f_misaligned;
   logic [31:0] pc_f_seq;

   assign pc_f_misaligned = (pc_f_q[1:0] != 2'b00);
   assign pc_f_seq        = pc_f_q + 32'd4;

   always_comb begin
      pc_f_d      = pc_f_q;
      dec_pc_d    = dec_pc_q;
      dec_valid_d = dec_valid_q;
      dec_adel_d  = dec_adel_q;
      dec_ds_d    = dec_ds_q;
      buf_valid_d = buf_valid_q;
      buf_instr_d = buf_instr_q;

      if (bus.flush) begin
         // Squash decode; pc_d is left as-is since valid_d=0 masks it.
         pc_f_d      = bus.newpc;
         dec_valid_d = 1'b0;
         dec_adel_d  = 1'b0;
         dec_ds_d    = 1'b0;
         buf_valid_d = 1'b0;
      end else if (bus.stall) begin
         // Only the first stall edge sees the SRAM word for pc_d; after that
         // the SRAM output is the word for pc_f, which must not overwrite it.
         // A taken branch here is dropped: decode re-asserts it on release.
         if (!buf_valid_q) begin
            buf_instr_d = bus.inst_sram_rdata;
            buf_valid_d = 1'b1;
         end
      end else begin
         // The slot at pc_f is latched before the branch redirect takes effect.
         dec_pc_d    = pc_f_q;
         dec_valid_d = 1'b1;
         dec_adel_d  = pc_f_misaligned;
         dec_ds_d    = bus.branch_d & dec_valid_q;
         buf_valid_d = 1'b0;
         pc_f_d      = bus.branch_taken ? bus.branch_target : pc_f_seq;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         pc_f_q      <= RESET_PC;
         dec_pc_q    <= 32'h0;
         dec_valid_q <= 1'b0;
         dec_adel_q  <= 1'b0;
         dec_ds_q    <= 1'b0;
         buf_valid_q <= 1'b0;
         buf_instr_q <= 32'h0;
      end else begin
         pc_f_q      <= pc_f_d;
         dec_pc_q    <= dec_pc_d;
         dec_valid_q <= dec_valid_d;
         dec_adel_q  <= dec_adel_d;
         dec_ds_q    <= dec_ds_d;
         buf_valid_q <= buf_valid_d;
         buf_instr_q <= buf_instr_d;
      end
   end

   // A misaligned PC is never presented to the SRAM as a real read.
   assign bus.inst_sram_en    = resetn & ~pc_f_misaligned;
   assign bus.inst_sram_wen   = 4'b0000;
   assign bus.inst_sram_addr  = pc_f_q;
   assign bus.inst_sram_wdata = 32'h0;

   assign bus.pc_d           = dec_pc_q;
   assign bus.valid_d        = dec_valid_q;
   assign bus.adel_d         = dec_adel_q;
   assign bus.in_delayslot_d = dec_ds_q;
   assign bus.instr_d        = (!dec_valid_q || dec_adel_q) ? 32'h0 :
                               (buf_valid_q ? buf_instr_q : bus.inst_sram_rdata);

endmodule
